// File: rtl/goose_pkg.sv
// rtl/goose_pkg.sv - shared types and constants for the goose animation sequencer
package goose_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPIN  = 2'd1,
        ST_DECEL = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] BG_GRASS = 2'd0;
    localparam logic [1:0] BG_UW    = 2'd1;
    localparam logic [1:0] BG_FIX0  = 2'd2;
    localparam logic [1:0] BG_FIX1  = 2'd3;

    localparam int DECEL_MAX_MULT = 8;

    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_debouncer.sv
// rtl/frame_debouncer.sv - button synchronizer with once-per-frame debounce and press pulse
module frame_debouncer
    import goose_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_frame_start,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = width_min1(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_differs;
    logic          w_flip;

    assign w_differs = (r_sync2 != r_level);
    assign w_flip    = i_frame_start && w_differs && (r_cnt == CNT_LAST);
    // press is combinational so the sequencer can act in the flipping frame
    assign o_press   = w_flip && !r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (i_frame_start) begin
                if (!w_differs) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_cnt   <= '0;
                    r_level <= ~r_level;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/goose_anim_ctrl.sv
// rtl/goose_anim_ctrl.sv - per-frame spin/decelerate/idle/hold sequencer for the goose VGA datapath
module goose_anim_ctrl
    import goose_pkg::*;
#(
    parameter int SPIN_DIV        = 4,
    parameter int SPIN_ROTATIONS  = 8,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int BG_CYCLE_ROT    = 4,
    parameter int AUTO_START      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       btn,
    input  logic       auto_bg,
    input  logic [1:0] bg_manual,
    output logic [1:0] frame_num,
    output logic [1:0] bg_sel,
    output logic       sound_en,
    output logic [6:0] frame_counter,
    output logic [1:0] state
);

    localparam int DW = $clog2(DECEL_MAX_MULT * SPIN_DIV);
    localparam int CW = DW + 1;
    localparam int RW = width_min1(SPIN_ROTATIONS);
    localparam int BW = width_min1(BG_CYCLE_ROT);

    localparam logic [CW-1:0] DIV_SPIN  = CW'(SPIN_DIV);
    localparam logic [CW-1:0] DIV_DECEL = CW'(2 * SPIN_DIV);
    localparam logic [CW-1:0] DIV_MAX   = CW'(DECEL_MAX_MULT * SPIN_DIV);
    localparam logic [RW-1:0] ROT_LAST  = RW'(SPIN_ROTATIONS - 1);
    localparam logic [BW-1:0] BG_LAST   = BW'(BG_CYCLE_ROT - 1);

    state_t        r_state;
    logic [1:0]    r_frame_num;
    logic [1:0]    r_bg_sel;
    logic          r_sound_en;
    logic [6:0]    r_frame_counter;
    logic [DW-1:0] r_div_cnt;
    logic [RW-1:0] r_rot_cnt;
    logic [CW-1:0] r_cur_div;
    logic [BW-1:0] r_bg_rot;
    logic          r_first;

    state_t        w_state_nxt;
    logic [1:0]    w_frame_nxt;
    logic [1:0]    w_bg_nxt;
    logic          w_sound_nxt;
    logic [6:0]    w_fc_nxt;
    logic [DW-1:0] w_div_nxt;
    logic [RW-1:0] w_rot_nxt;
    logic [CW-1:0] w_cur_nxt;
    logic [BW-1:0] w_bg_rot_nxt;
    logic          w_first_nxt;
    logic          w_press;
    logic          w_div_hit;
    logic          w_step_wrap;
    logic          w_wrap;
    logic [CW-1:0] w_div_last;

    frame_debouncer #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_start(frame_start),
        .i_btn        (btn),
        .o_press      (w_press)
    );

    assign w_div_last  = r_cur_div - CW'(1);
    assign w_div_hit   = ({1'b0, r_div_cnt} == w_div_last);
    assign w_step_wrap = w_div_hit && (r_frame_num == 2'd3);

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_nxt  = r_frame_num;
        w_bg_nxt     = r_bg_sel;
        w_sound_nxt  = r_sound_en;
        w_fc_nxt     = r_frame_counter;
        w_div_nxt    = r_div_cnt;
        w_rot_nxt    = r_rot_cnt;
        w_cur_nxt    = r_cur_div;
        w_bg_rot_nxt = r_bg_rot;
        w_first_nxt  = r_first;
        w_wrap       = 1'b0;

        if (frame_start) begin
            w_fc_nxt    = r_frame_counter + 7'd1;
            w_first_nxt = 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    w_frame_nxt = 2'd0;
                    if (w_press || ((AUTO_START != 0) && r_first)) begin
                        w_state_nxt = ST_SPIN;
                        w_div_nxt   = '0;
                        w_rot_nxt   = '0;
                        w_cur_nxt   = DIV_SPIN;
                    end
                end
                ST_SPIN: begin
                    if (w_press) begin
                        w_state_nxt = ST_HOLD;
                        w_div_nxt   = '0;
                    end else if (w_div_hit) begin
                        w_div_nxt   = '0;
                        w_frame_nxt = r_frame_num + 2'd1;
                        w_wrap      = w_step_wrap;
                        if (w_step_wrap) begin
                            w_rot_nxt = r_rot_cnt + RW'(1);
                            if (r_rot_cnt == ROT_LAST) begin
                                w_state_nxt = ST_DECEL;
                                w_cur_nxt   = DIV_DECEL;
                            end
                        end
                    end else begin
                        w_div_nxt = r_div_cnt + DW'(1);
                    end
                end
                ST_DECEL: begin
                    if (w_press) begin
                        w_state_nxt = ST_SPIN;
                        w_div_nxt   = '0;
                        w_rot_nxt   = '0;
                        w_cur_nxt   = DIV_SPIN;
                    end else if (w_div_hit) begin
                        w_div_nxt   = '0;
                        w_frame_nxt = r_frame_num + 2'd1;
                        w_wrap      = w_step_wrap;
                        if (w_step_wrap) begin
                            if (r_cur_div == DIV_MAX) begin
                                w_state_nxt = ST_IDLE;
                                w_cur_nxt   = DIV_SPIN;
                            end else begin
                                w_cur_nxt = {r_cur_div[CW-2:0], 1'b0};
                            end
                        end
                    end else begin
                        w_div_nxt = r_div_cnt + DW'(1);
                    end
                end
                ST_HOLD: begin
                    w_div_nxt = '0;
                    if (w_press) begin
                        w_state_nxt = ST_SPIN;
                        w_cur_nxt   = DIV_SPIN;
                    end
                end
            endcase
            w_sound_nxt = (w_state_nxt == ST_SPIN) || (w_state_nxt == ST_DECEL);
        end

        if (w_wrap) begin
            if (r_bg_rot == BG_LAST) begin
                w_bg_rot_nxt = '0;
                w_bg_nxt     = r_bg_sel + 2'd1;
            end else begin
                w_bg_rot_nxt = r_bg_rot + BW'(1);
            end
        end
        // Manual mode tracks bg_manual every clock; on return to auto it resumes from that copy
        if (!auto_bg) begin
            w_bg_nxt = bg_manual;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_frame_num     <= 2'd0;
            r_bg_sel        <= BG_GRASS;
            r_sound_en      <= 1'b0;
            r_frame_counter <= 7'd0;
            r_div_cnt       <= '0;
            r_rot_cnt       <= '0;
            r_cur_div       <= DIV_SPIN;
            r_bg_rot        <= '0;
            r_first         <= 1'b1;
        end else begin
            r_state         <= w_state_nxt;
            r_frame_num     <= w_frame_nxt;
            r_bg_sel        <= w_bg_nxt;
            r_sound_en      <= w_sound_nxt;
            r_frame_counter <= w_fc_nxt;
            r_div_cnt       <= w_div_nxt;
            r_rot_cnt       <= w_rot_nxt;
            r_cur_div       <= w_cur_nxt;
            r_bg_rot        <= w_bg_rot_nxt;
            r_first         <= w_first_nxt;
        end
    end

    assign frame_num     = r_frame_num;
    assign bg_sel        = r_bg_sel;
    assign sound_en      = r_sound_en;
    assign frame_counter = r_frame_counter;
    assign state         = r_state;

endmodule

// File: tb/tb_goose_anim_ctrl.sv
// tb/tb_goose_anim_ctrl.sv - scoreboard bench for goose_anim_ctrl against a frame-level model
module tb_goose_anim_ctrl;

    localparam int SPIN_DIV = 4;
    localparam int SPIN_ROT = 2;
    localparam int DB       = 3;
    localparam int BGC      = 1;
    localparam int GAP      = 8;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       btn = 1'b0;
    logic       auto_bg = 1'b1;
    logic [1:0] bg_manual = 2'd0;
    logic [1:0] frame_num;
    logic [1:0] bg_sel;
    logic       sound_en;
    logic [6:0] frame_counter;
    logic [1:0] state;
    logic       fs_d = 1'b0;

    goose_anim_ctrl #(
        .SPIN_DIV       (SPIN_DIV),
        .SPIN_ROTATIONS (SPIN_ROT),
        .DEBOUNCE_FRAMES(DB),
        .BG_CYCLE_ROT   (BGC),
        .AUTO_START     (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .btn          (btn),
        .auto_bg      (auto_bg),
        .bg_manual    (bg_manual),
        .frame_num    (frame_num),
        .bg_sel       (bg_sel),
        .sound_en     (sound_en),
        .frame_counter(frame_counter),
        .state        (state)
    );

    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        int st;
        int fr;
        int bg;
        int snd;
        int fc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // frame-level model: states 0 idle, 1 spin, 2 decel, 3 hold
    int m_state = 0, m_frame = 0, m_tick = 0, m_period = SPIN_DIV, m_rot = 0;
    int m_fc = 0, m_bg = 0, m_bgw = 0, m_lvl = 0, m_run = 0;
    bit m_first = 1'b1;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic spin_fresh();
        m_state  = 1;
        m_tick   = 0;
        m_rot    = 0;
        m_period = SPIN_DIV;
    endtask

    task automatic advance(output bit w);
        w = 1'b0;
        m_tick++;
        if (m_tick == m_period) begin
            m_tick  = 0;
            m_frame = (m_frame + 1) % 4;
            w       = (m_frame == 0);
        end
    endtask

    task automatic model_pulse();
        bit press = 1'b0;
        bit wrap = 1'b0;
        if (int'(btn) != m_lvl) begin
            m_run++;
            if (m_run == DB) begin
                m_lvl = int'(btn);
                m_run = 0;
                press = btn;
            end
        end else begin
            m_run = 0;
        end
        m_fc = (m_fc + 1) % 128;
        case (m_state)
            0: if (press || m_first) spin_fresh();
            1: begin
                if (press) begin
                    m_state = 3;
                    m_tick  = 0;
                end else begin
                    advance(wrap);
                    if (wrap) begin
                        m_rot++;
                        if (m_rot == SPIN_ROT) begin
                            m_state  = 2;
                            m_period = 2 * SPIN_DIV;
                            m_tick   = 0;
                        end
                    end
                end
            end
            2: begin
                if (press) spin_fresh();
                else begin
                    advance(wrap);
                    if (wrap) begin
                        if (m_period == 8 * SPIN_DIV) m_state = 0;
                        else m_period = m_period * 2;
                    end
                end
            end
            default: begin
                if (press) begin
                    m_state  = 1;
                    m_period = SPIN_DIV;
                    m_tick   = 0;
                end
            end
        endcase
        m_first = 1'b0;
        if (wrap) begin
            m_bgw++;
            if (m_bgw == BGC) begin
                m_bgw = 0;
                if (auto_bg) m_bg = (m_bg + 1) % 4;
            end
        end
        if (!auto_bg) m_bg = int'(bg_manual);
    endtask

    task automatic pulse();
        exp_t e;
        repeat (GAP - 1) @(posedge clk);
        #1;
        frame_start = 1'b1;
        model_pulse();
        e.st  = m_state;
        e.fr  = m_frame;
        e.bg  = m_bg;
        e.snd = (m_state == 1 || m_state == 2) ? 1 : 0;
        e.fc  = m_fc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    always @(posedge clk) fs_d <= frame_start;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (fs_d) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                e = sb_q.pop_front();
                chk("sb_state", int'(state), e.st);
                chk("sb_frame", int'(frame_num), e.fr);
                chk("sb_bg", int'(bg_sel), e.bg);
                chk("sb_sound", int'(sound_en), e.snd);
                chk("sb_fc", int'(frame_counter), e.fc);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_frame", int'(frame_num), 0);
        chk("rst_bg", int'(bg_sel), 0);
        chk("rst_sound", int'(sound_en), 0);
        chk("rst_fc", int'(frame_counter), 0);
        rst_n = 1'b1;

        // autostart, spin rate, decel into idle
        for (int k = 1; k <= 257; k++) begin
            pulse();
            if (k == 1) begin
                chk("p1_state", int'(state), 1);
                chk("p1_frame", int'(frame_num), 0);
                chk("p1_sound", int'(sound_en), 1);
            end
            if (k == 4)   chk("p4_frame", int'(frame_num), 0);
            if (k == 5)   chk("p5_frame", int'(frame_num), 1);
            if (k == 9)   chk("p9_frame", int'(frame_num), 2);
            if (k == 13)  chk("p13_frame", int'(frame_num), 3);
            if (k == 16)  chk("p16_bg", int'(bg_sel), 0);
            if (k == 17) begin
                chk("p17_frame", int'(frame_num), 0);
                chk("p17_bg", int'(bg_sel), 1);
            end
            if (k == 32)  chk("p32_state", int'(state), 1);
            if (k == 33)  chk("p33_state", int'(state), 2);
            if (k == 41)  chk("p41_frame", int'(frame_num), 1);
            if (k == 80)  chk("p80_frame", int'(frame_num), 0);
            if (k == 81)  chk("p81_frame", int'(frame_num), 1);
            if (k == 127) chk("p127_fc", int'(frame_counter), 127);
            if (k == 128) chk("p128_fc", int'(frame_counter), 0);
            if (k == 256) begin
                chk("p256_state", int'(state), 2);
                chk("p256_frame", int'(frame_num), 3);
            end
            if (k == 257) begin
                chk("p257_state", int'(state), 0);
                chk("p257_frame", int'(frame_num), 0);
                chk("p257_sound", int'(sound_en), 0);
            end
        end

        // short button burst is rejected; three frames accepted
        btn = 1'b1;
        pulses(2);
        btn = 1'b0;
        pulses(2);
        chk("short_btn_state", int'(state), 0);
        btn = 1'b1;
        pulses(2);
        chk("db_pre_state", int'(state), 0);
        pulse();
        chk("db_press_state", int'(state), 1);
        btn = 1'b0;

        // hold at frame 2 then resume
        for (int i = 0; i < 40 && !(m_state == 1 && m_frame == 2 && m_tick == 0 && m_lvl == 0 && m_run == 0); i++)
            pulse();
        btn = 1'b1;
        pulses(3);
        chk("hold_state", int'(state), 3);
        chk("hold_frame", int'(frame_num), 2);
        btn = 1'b0;
        pulses(100);
        chk("hold100_state", int'(state), 3);
        chk("hold100_frame", int'(frame_num), 2);
        chk("hold100_sound", int'(sound_en), 0);
        btn = 1'b1;
        pulses(3);
        chk("resume_state", int'(state), 1);
        chk("resume_frame", int'(frame_num), 2);
        btn = 1'b0;
        pulses(3);
        chk("resume3_frame", int'(frame_num), 2);
        pulse();
        chk("resume4_frame", int'(frame_num), 3);

        // press coincident with a wrap wins
        for (int i = 0; i < 40 && !(m_state == 1 && m_frame == 3 && m_tick == 0 && m_lvl == 0 && m_run == 0); i++)
            pulse();
        pulses(SPIN_DIV - DB);
        btn = 1'b1;
        pulses(3);
        chk("wrap_press_state", int'(state), 3);
        chk("wrap_press_frame", int'(frame_num), 3);
        btn = 1'b0;
        pulses(3);
        btn = 1'b1;
        pulses(3);
        btn = 1'b0;
        chk("wrap_resume_state", int'(state), 1);
        pulses(SPIN_DIV);
        chk("wrap_after_frame", int'(frame_num), 0);
        chk("wrap_after_state", int'(state), int'(m_state));

        // manual background path latency
        auto_bg = 1'b0;
        bg_manual = 2'd1;
        m_bg = 1;
        @(posedge clk);
        #1;
        bg_manual = 2'd2;
        m_bg = 2;
        chk("bgm_prev", int'(bg_sel), 1);
        @(posedge clk);
        #1;
        chk("bgm_latency", int'(bg_sel), 2);

        // randomized button and background activity
        hold = 0;
        for (int i = 0; i < 200; i++) begin
            if (hold == 0) begin
                btn  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 6);
            end
            hold--;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    auto_bg = ~auto_bg;
                    if (!auto_bg) m_bg = int'(bg_manual);
                end else begin
                    bg_manual = 2'($urandom_range(0, 3));
                    if (!auto_bg) m_bg = int'(bg_manual);
                end
            end
            pulse();
        end

        // drive into DECEL, then reset with the clock stopped
        auto_bg = 1'b1;
        for (int i = 0; i < 800 && m_state != 2; i++) begin
            btn = ((m_state == 0 || m_state == 3) && m_lvl == 0) ? 1'b1 : 1'b0;
            pulse();
        end
        chk("reach_decel", int'(state), 2);
        btn = 1'b0;
        pulses(2);
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_frame", int'(frame_num), 0);
        chk("async_rst_bg", int'(bg_sel), 0);
        chk("async_rst_sound", int'(sound_en), 0);
        chk("async_rst_fc", int'(frame_counter), 0);
        #10;
        rst_n = 1'b1;
        m_state = 0; m_frame = 0; m_tick = 0; m_period = SPIN_DIV; m_rot = 0;
        m_fc = 0; m_bg = 0; m_bgw = 0; m_lvl = 0; m_run = 0; m_first = 1'b1;
        #2;
        clk_run = 1'b1;
        pulse();
        chk("restart_state", int'(state), 1);
        chk("restart_fc", int'(frame_counter), 1);
        pulses(5);
        chk("restart5_frame", int'(frame_num), 1);

        @(negedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
